// File: rtl/universal_load_register.sv
// WIDTH-bit register with hold, load, shift, rotate and up/down count modes.
// Registered carry/shift-out and change flags, combinational zero flag.
module universal_load_register #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             zero,
  output logic             changed
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_INC  = 3'b110,
    M_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;
  logic             chg_q, chg_d;
  logic [WIDTH:0]   inc_w, dec_w;
  mode_e            mode_w;

  assign mode_w = mode_e'(mode);
  assign inc_w  = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
  // Top bit of the widened difference is the borrow out of q - 1.
  assign dec_w  = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    q_d    = q_q;
    cout_d = cout_q;
    if (en) begin
      unique case (mode_w)
        M_HOLD: begin
          q_d    = q_q;
          cout_d = cout_q;
        end
        M_LOAD: begin
          q_d    = d_in;
          cout_d = 1'b0;
        end
        M_SHL: begin
          q_d    = {q_q[WIDTH-2:0], ser_in};
          cout_d = q_q[WIDTH-1];
        end
        M_SHR: begin
          q_d    = {ser_in, q_q[WIDTH-1:1]};
          cout_d = q_q[0];
        end
        M_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          cout_d = q_q[WIDTH-1];
        end
        M_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          cout_d = q_q[0];
        end
        M_INC: begin
          q_d    = inc_w[WIDTH-1:0];
          cout_d = inc_w[WIDTH];
        end
        M_DEC: begin
          q_d    = dec_w[WIDTH-1:0];
          cout_d = dec_w[WIDTH];
        end
      endcase
    end
  end

  // Change is judged on the value, not the mode.
  assign chg_d = (q_d != q_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      cout_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      cout_q <= cout_d;
      chg_q  <= chg_d;
    end
  end

  assign q       = q_q;
  assign cout    = cout_q;
  assign changed = chg_q;
  assign zero    = (q_q == '0);

endmodule

// File: tb/tb_universal_load_register.sv
// Directed bench for universal_load_register at WIDTH 4, 2 and 16.
// Expected values are hand-computed constants.
module tb_universal_load_register;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] SHL  = 3'b010;
  localparam logic [2:0] SHR  = 3'b011;
  localparam logic [2:0] ROL  = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] INC  = 3'b110;
  localparam logic [2:0] DEC  = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en_v;
  logic [2:0]  mode;
  logic [15:0] d;
  logic        ser;

  logic [3:0]  q4;
  logic [1:0]  q2;
  logic [15:0] q16;
  logic        c4, c2, c16;
  logic        z4, z2, z16;
  logic        ch4, ch2, ch16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  universal_load_register #(.WIDTH(4), .RESET_VAL(4'hA)) u4 (
    .clk(clk), .rst(rst), .en(en_v[0]), .mode(mode),
    .d_in(d[3:0]), .ser_in(ser),
    .q(q4), .cout(c4), .zero(z4), .changed(ch4)
  );

  universal_load_register #(.WIDTH(2), .RESET_VAL(2'b00)) u2 (
    .clk(clk), .rst(rst), .en(en_v[1]), .mode(mode),
    .d_in(d[1:0]), .ser_in(ser),
    .q(q2), .cout(c2), .zero(z2), .changed(ch2)
  );

  universal_load_register #(.WIDTH(16), .RESET_VAL(16'h0000)) u16 (
    .clk(clk), .rst(rst), .en(en_v[2]), .mode(mode),
    .d_in(d), .ser_in(ser),
    .q(q16), .cout(c16), .zero(z16), .changed(ch16)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Apply one operation to the selected DUTs and sample after the edge.
  task automatic op(input logic [2:0]  sel,
                    input logic [2:0]  m,
                    input logic [15:0] dv,
                    input logic        s);
    en_v = sel;
    mode = m;
    d    = dv;
    ser  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] eq,
                      input logic ec, input logic ez,
                      input logic ech);
    check({tag, ".q"}, 64'(q4), 64'(eq));
    check({tag, ".cout"}, 64'(c4), 64'(ec));
    check({tag, ".zero"}, 64'(z4), 64'(ez));
    check({tag, ".chg"}, 64'(ch4), 64'(ech));
  endtask

  initial begin
    rst  = 1'b1;
    en_v = 3'b111;
    mode = INC;
    d    = '0;
    ser  = 1'b0;

    // reset held two edges while INC is requested
    op(3'b111, INC, 16'h0, 1'b0);
    chk4("rst1", 4'hA, 1'b0, 1'b0, 1'b0);
    op(3'b111, INC, 16'h0, 1'b0);
    chk4("rst2", 4'hA, 1'b0, 1'b0, 1'b0);
    check("rst2.q2", 64'(q2), 64'h0);
    check("rst2.z2", 64'(z2), 64'h1);
    rst = 1'b0;
    op(3'b001, INC, 16'h0, 1'b0);
    chk4("rel", 4'hB, 1'b0, 1'b0, 1'b1);

    // legacy load then disabled hold
    op(3'b001, LOAD, 16'h6, 1'b0);
    chk4("ld6", 4'h6, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      op(3'b000, LOAD, 16'h9, 1'b1);
      chk4("en0", 4'h6, 1'b0, 1'b0, 1'b0);
    end

    // shift and rotate
    op(3'b001, LOAD, 16'h9, 1'b0);
    chk4("ld9", 4'h9, 1'b0, 1'b0, 1'b1);
    op(3'b001, SHL, 16'h0, 1'b0);
    chk4("shl", 4'h2, 1'b1, 1'b0, 1'b1);
    op(3'b001, SHR, 16'h0, 1'b1);
    chk4("shr", 4'h9, 1'b0, 1'b0, 1'b1);
    op(3'b001, ROR, 16'h0, 1'b0);
    chk4("ror", 4'hC, 1'b1, 1'b0, 1'b1);
    op(3'b001, ROL, 16'h0, 1'b0);
    chk4("rol", 4'h9, 1'b1, 1'b0, 1'b1);

    // count wrap
    op(3'b001, LOAD, 16'hE, 1'b0);
    chk4("ldE", 4'hE, 1'b0, 1'b0, 1'b1);
    op(3'b001, INC, 16'h0, 1'b0);
    chk4("inc1", 4'hF, 1'b0, 1'b0, 1'b1);
    op(3'b001, INC, 16'h0, 1'b0);
    chk4("inc2", 4'h0, 1'b1, 1'b1, 1'b1);
    op(3'b001, DEC, 16'h0, 1'b0);
    chk4("dec", 4'hF, 1'b1, 1'b0, 1'b1);
    op(3'b001, HOLD, 16'h3, 1'b1);
    chk4("hold", 4'hF, 1'b1, 1'b0, 1'b0);

    // change detection
    op(3'b001, LOAD, 16'hF, 1'b0);
    chk4("ldF", 4'hF, 1'b0, 1'b0, 1'b0);
    op(3'b001, ROL, 16'h0, 1'b0);
    chk4("rolF", 4'hF, 1'b1, 1'b0, 1'b0);
    op(3'b001, INC, 16'h0, 1'b0);
    chk4("incF", 4'h0, 1'b1, 1'b1, 1'b1);

    // WIDTH = 2 count wrap
    op(3'b010, LOAD, 16'h2, 1'b0);
    check("w2.ld", 64'(q2), 64'h2);
    op(3'b010, INC, 16'h0, 1'b0);
    check("w2.inc1", 64'(q2), 64'h3);
    check("w2.c1", 64'(c2), 64'h0);
    op(3'b010, INC, 16'h0, 1'b0);
    check("w2.inc2", 64'(q2), 64'h0);
    check("w2.c2", 64'(c2), 64'h1);
    check("w2.z2", 64'(z2), 64'h1);
    op(3'b010, DEC, 16'h0, 1'b0);
    check("w2.dec", 64'(q2), 64'h3);
    check("w2.cd", 64'(c2), 64'h1);
    check("w2.zd", 64'(z2), 64'h0);
    check("w2.u4", 64'(q4), 64'h0);

    // WIDTH = 16 count wrap
    op(3'b100, LOAD, 16'hFFFF, 1'b0);
    check("w16.ld", 64'(q16), 64'hFFFF);
    check("w16.zl", 64'(z16), 64'h0);
    op(3'b100, INC, 16'h0, 1'b0);
    check("w16.inc", 64'(q16), 64'h0);
    check("w16.c", 64'(c16), 64'h1);
    check("w16.z", 64'(z16), 64'h1);
    check("w16.ch", 64'(ch16), 64'h1);

    // reset wins over INC on the same edge
    op(3'b111, LOAD, 16'h5, 1'b0);
    rst = 1'b1;
    op(3'b111, INC, 16'h0, 1'b0);
    chk4("rstinc", 4'hA, 1'b0, 1'b0, 1'b0);
    check("rstinc.q2", 64'(q2), 64'h0);
    check("rstinc.q16", 64'(q16), 64'h0);
    check("rstinc.c16", 64'(c16), 64'h0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
